// File: rtl/edge_generator.sv
// Output-pin edge generator: rise/fall edges, timed pulses or level pass-through,
// with sticky done flag and maskable irq. Optional macro PULSE_REPEAT_EN adds pulse trains.
module edge_generator #(
    parameter int   LEN_W      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    output logic             ready,
    input  logic [1:0]       select_edge,
    input  logic [LEN_W-1:0] pulse_len,
    input  logic             data,
    input  logic             clr,
    input  logic             interrupt_mask,
`ifdef PULSE_REPEAT_EN
    input  logic [7:0]       pulse_count,
`endif
    output logic             dout,
    output logic             busy,
    output logic             edge_done,
    output logic             irq
);

`ifdef PULSE_REPEAT_EN
    typedef enum logic [1:0] {IDLE, PULSE, PASS, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, PULSE, PASS} state_t;
`endif

    state_t           state, state_n;
    logic             dout_n, busy_n, done_n, set_done;
    logic [LEN_W-1:0] counter, counter_n, len_eff;
`ifdef PULSE_REPEAT_EN
    logic [LEN_W-1:0] len_q, len_n;
    logic [7:0]       left_q, left_n;
`endif

    // A zero length counts as one so the counter never wraps.
    assign len_eff = (pulse_len == '0) ? LEN_W'(1) : pulse_len;

    assign ready = enable & ((state == IDLE) | (state == PASS));
    assign irq   = edge_done & interrupt_mask;

    always_comb begin
        state_n   = state;
        dout_n    = dout;
        busy_n    = busy;
        counter_n = counter;
        set_done  = 1'b0;
`ifdef PULSE_REPEAT_EN
        len_n     = len_q;
        left_n    = left_q;
`endif
        if (enable) begin
            case (state)
                IDLE, PASS: begin
                    if (start) begin
                        case (select_edge)
                            2'b00: begin dout_n = 1'b1; set_done = 1'b1; state_n = IDLE; end
                            2'b01: begin dout_n = 1'b0; set_done = 1'b1; state_n = IDLE; end
                            2'b10: begin
                                dout_n    = ~dout;
                                counter_n = len_eff;
                                busy_n    = 1'b1;
                                state_n   = PULSE;
`ifdef PULSE_REPEAT_EN
                                len_n     = len_eff;
                                left_n    = (pulse_count == 8'd0) ? 8'd1 : pulse_count;
`endif
                            end
                            default: begin dout_n = data; state_n = PASS; end
                        endcase
                    end else if (state == PASS) begin
                        dout_n = data;
                    end
                end
                PULSE: begin
                    if (counter == LEN_W'(1)) begin
                        dout_n = ~dout;
`ifdef PULSE_REPEAT_EN
                        if (left_q > 8'd1) begin
                            // Restore level, then hold it for one pulse length before the next pulse.
                            left_n    = left_q - 8'd1;
                            counter_n = len_q;
                            state_n   = GAP;
                        end else begin
                            busy_n    = 1'b0;
                            set_done  = 1'b1;
                            counter_n = '0;
                            state_n   = IDLE;
                        end
`else
                        busy_n    = 1'b0;
                        set_done  = 1'b1;
                        counter_n = '0;
                        state_n   = IDLE;
`endif
                    end else begin
                        counter_n = counter - LEN_W'(1);
                    end
                end
`ifdef PULSE_REPEAT_EN
                GAP: begin
                    if (counter == LEN_W'(1)) begin
                        dout_n    = ~dout;
                        counter_n = len_q;
                        state_n   = PULSE;
                    end else begin
                        counter_n = counter - LEN_W'(1);
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
        // A set in the same cycle as clr wins so no completion is lost.
        if (!enable)
            done_n = edge_done;
        else if (set_done)
            done_n = 1'b1;
        else if (clr)
            done_n = 1'b0;
        else
            done_n = edge_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dout      <= IDLE_LEVEL;
            busy      <= 1'b0;
            edge_done <= 1'b0;
            counter   <= '0;
`ifdef PULSE_REPEAT_EN
            len_q     <= '0;
            left_q    <= '0;
`endif
        end else begin
            state     <= state_n;
            dout      <= dout_n;
            busy      <= busy_n;
            edge_done <= done_n;
            counter   <= counter_n;
`ifdef PULSE_REPEAT_EN
            len_q     <= len_n;
            left_q    <= left_n;
`endif
        end
    end

endmodule
